// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract unit.
// Each clock sums CHUNK bits of the operands and passes the carry to the next chunk.
// Operands and results use valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | summing one chunk per cycle, LSB chunk first
// DONE  | result presented, held until out_ready
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK:0]         chunk_sum;
    logic [CHUNK-1:0]       psum;
    logic                   c_out;
    logic                   c_msb_in;
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic                   last_chunk;

    // Chunk adder; the carry into the chunk MSB is recovered from sum and operand bits.
    always_comb begin
        chunk_sum  = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};
        psum       = chunk_sum[CHUNK-1:0];
        c_out      = chunk_sum[CHUNK];
        c_msb_in   = psum[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
        sum_cat    = {psum, sum};
        last_chunk = (cnt == CW'(NCH - 1));
    end

    // Handshake outputs come straight from the state; rst masks acceptance in its own cycle.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    sum   <= sum_cat[WIDTH+CHUNK-1:CHUNK];
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        cout  <= c_out;
                        ovf   <= c_msb_in ^ c_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder.
// Covers a CHUNK=4 instance (main) and a CHUNK=16 instance (single-cycle RUN).
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        in_ready2, out_valid2, cout2, ovf2;
    logic [15:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] q[$];
    logic [17:0] q2[$];

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Reference: full-width arithmetic, returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                          input logic c, input logic s);
        logic [15:0] be;
        logic        ce;
        logic [16:0] full;
        logic        o;
        be   = s ? ~bb : bb;
        ce   = s ? ~c : c;
        full = {1'b0, aa} + {1'b0, be} + {16'd0, ce};
        o    = (aa[15] == be[15]) && (full[15] != aa[15]);
        return {o, full[16], full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation on the CHUNK=4 instance; called at a negedge with the DUT idle.
    // stall: cycles of out_ready=0 after out_valid; junk: keep in_valid high with new operands.
    task automatic do_op(input logic [15:0] aa, input logic [15:0] bb, input logic c,
                         input logic s, input int stall, input bit junk);
        logic [17:0] exp;
        int cyc;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a = aa; b = bb; cin = c; sub = s;
        q.push_back(model(aa, bb, c, s));
        @(negedge clk);
        if (junk) begin
            a = ~aa; b = bb ^ 16'h5a5a; cin = ~c; sub = ~s;
        end else begin
            in_valid = 1'b0;
        end
        check("in_ready_run", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 32'd4);
        if (q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = q.pop_front();
        end
        check("sum", {16'd0, sum}, {16'd0, exp[15:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[16]});
        check("ovf", {31'd0, ovf}, {31'd0, exp[17]});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_res", {14'd0, ovf, cout, sum}, {14'd0, exp});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        check("idle_sum_kept", {16'd0, sum}, {16'd0, exp[15:0]});
    endtask

    initial begin
        int cyc;
        logic [17:0] e2;

        // Reset cycle
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outs", {14'd0, ovf, cout, sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h0FED, 1'b1, 1'b0, 1, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        // Backpressure with junk operands offered during RUN/DONE
        do_op(16'h4321, 16'h1111, 1'b1, 1'b1, 3, 1'b1);

        // Reset during RUN: rst sampled at edge 2 of the op
        in_valid = 1'b1; a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0;
        q.push_back(model(16'h1357, 16'h2468, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        void'(q.pop_back());
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h0100, 16'h0200, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom));
        end

        // CHUNK=16 instance
        check("c16_in_ready", {31'd0, in_ready2}, 32'd1);
        in_valid2 = 1'b1; a2 = 16'hAAAA; b2 = 16'h5555; cin2 = 1'b1; sub2 = 1'b0;
        q2.push_back(model(16'hAAAA, 16'h5555, 1'b1, 1'b0));
        @(negedge clk);
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("c16_latency", cyc, 32'd1);
        e2 = (q2.size() != 0) ? q2.pop_front() : 18'h3FFFF;
        check("c16_result", {14'd0, ovf2, cout2, sum2}, {14'd0, e2});
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("c16_post_valid", {31'd0, out_valid2}, 32'd0);
        check("c16_post_ready", {31'd0, in_ready2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. It is the sequential successor to the combinational 1-bit full adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks.
- Valid/ready handshake on both input and output, so it sits between producer and consumer stages in datapaths where a full-width carry chain is too slow or too large.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits summed per clock cycle; 1 ≤ CHUNK ≤ WIDTH. NCH = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/cmd valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a−b−cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset:
  - state=IDLE.
  - in_ready=0 during the rst cycle, 1 the cycle after.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - Internal operand, carry and counter registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture A=a and B=(sub ? ~b : b).
  - Capture carry = sub ? ~cin : cin; chunk counter=0; go to RUN.
- RUN:
  - in_ready=0; a, b, cin, sub and in_valid are ignored.
  - Each cycle, add the low CHUNK bits of A and B plus carry.
  - Shift the CHUNK-bit partial sum into the result register from the MSB side.
  - Shift A and B right by CHUNK; update carry; increment counter.
  - On the last chunk (counter==NCH−1):
    - Register cout = carry out of the MSB.
    - Register ovf = carry into the MSB XOR carry out of the MSB.
    - Go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
  - in_ready returns to 1 the next cycle; there is no same-cycle turnaround.
- Latency: the acceptance edge is edge 0; out_valid is first high after edge NCH.
  - Throughput is one operation per NCH+2 cycles when out_ready=1.
- CHUNK==WIDTH: NCH=1, so RUN lasts one cycle.
- sum remains at its last value in IDLE and is not cleared on handshake. Only rst clears it.
- rst asserted in RUN or DONE aborts the operation. No out_valid is produced for the aborted op; all outputs go to their reset values at that edge.
- rst has priority over every handshake at the same edge.
- Arithmetic:
  - Everything is modulo 2^WIDTH.
  - sub uses the ~b + (~cin) identity, so a−b−cin is exact modulo 2^WIDTH.
  - cout is the raw adder carry in both modes.

Test Plan (WIDTH=16, CHUNK=4):
- Add with wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → out_valid high after edge 4; sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 → sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x0FED, cin=1 → sum=0x2222, cout=0, ovf=0.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 3 cycles after out_valid → sum, cout and ovf are unchanged; in_ready stays 0.
  - in_valid with new operands during RUN/DONE is not consumed.
  - On release, in_ready=1 one cycle later.
- Reset mid-RUN: assert rst at edge 2 of an op → out_valid never rises for it; sum=0, state IDLE. The next op, 0x0100+0x0200, returns 0x0300.
- CHUNK=16 instance: 0xAAAA+0x5555, cin=1 → sum=0x0000, cout=1, with out_valid after edge 1.
